wb_port_arbiter: RTL

Arbitrates the single register-file write port between the in-order pipeline's WB stage and the multi-cycle multiply/divide unit's result path. WB-stage writes always win. MD results are buffered in a small FIFO and drained into idle write-port cycles. A starvation guard requests a pipeline bubble when a buffered result waits too long. A query port reports pending destination registers so the hazard unit can stall dependent instructions.

---
 rtl/wb_port_arbiter_pkg.sv | 11 +
 rtl/wb_md_fifo.sv | 59 +++++
 rtl/wb_port_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, r0 constant and arbiter state encoding.
package wb_port_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] R0 = '0;
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PEND,
    ARB_FORCE
  } arb_state_e;
endpackage

// File: rtl/wb_md_fifo.sv
// wb_md_fifo: DEPTH-entry {rn,data} buffer for MD results with a parallel rn match.
module wb_md_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [REG_W-1:0]           push_rn,
  input  logic [DATA_W-1:0]          push_data,
  input  logic [REG_W-1:0]           q_rn,
  output logic [$clog2(DEPTH):0]     count,
  output logic [REG_W-1:0]           head_rn,
  output logic [DATA_W-1:0]          head_data,
  output logic                       q_match
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [REG_W-1:0] rn_q [DEPTH];
  logic [REG_W-1:0] rn_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  assign count = cnt_q;
  assign head_rn = rn_q[rd_q];
  assign head_data = data_q[rd_q];
  always_comb begin
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    rn_d = rn_q;
    data_d = data_q;
    if (push) begin
      rn_d[wr_q] = push_rn;
      data_d[wr_q] = push_data;
    end
    q_match = 1'b0;
    // an entry is live when its distance from the read pointer is below count
    for (int i = 0; i < DEPTH; i++)
      if (q_rn != R0 && rn_q[i] == q_rn && {1'b0, PW'(i) - rd_q} < cnt_q) q_match = 1'b1;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rn_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rn_q <= rn_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB writes and
// buffered MD results, with a starvation guard requesting a pipeline bubble.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [DATA_W-1:0] walu,
  input  logic [DATA_W-1:0] wmo,
  input  logic [REG_W-1:0]  wrn,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rn,
  input  logic [DATA_W-1:0] md_result,
  output logic              md_ready,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wn,
  output logic [DATA_W-1:0] rf_wd,
  output logic              stall_req,
  input  logic [REG_W-1:0]  q_rn,
  output logic              q_hit
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] count;
  logic [REG_W-1:0] head_rn;
  logic [DATA_W-1:0] head_data;
  logic pipe_wr, empty, push, pop, last;
  logic [SW-1:0] starve_q, starve_d;
  arb_state_e state_q, state_d;
  wb_md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .clrn(clrn),
    .push(push),
    .pop(pop),
    .push_rn(md_rn),
    .push_data(md_result),
    .q_rn(q_rn),
    .count(count),
    .head_rn(head_rn),
    .head_data(head_data),
    .q_match(q_hit)
  );
  always_comb begin
    pipe_wr = wwreg & (wrn != R0);
    empty = count == '0;
    md_ready = count < CW'(DEPTH);
    // r0-targeted results complete the handshake but are dropped here
    push = md_valid & md_ready & (md_rn != R0);
    pop = clrn & ~pipe_wr & ~empty;
    last = pop & ~push & (count == CW'(1));
    rf_we = clrn & (pipe_wr | ~empty);
    rf_wn = !clrn ? R0 : pipe_wr ? wrn : empty ? R0 : head_rn;
    rf_wd = !clrn ? '0 : pipe_wr ? (wm2reg ? wmo : walu) : empty ? '0 : head_data;
    starve_d = (empty | pop) ? '0 : (pipe_wr && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
    stall_req = state_q == ARB_FORCE;
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  state_d = push ? ARB_PEND : ARB_IDLE;
      ARB_PEND:  state_d = last ? ARB_IDLE : (starve_d == SW'(STARVE_MAX)) ? ARB_FORCE : ARB_PEND;
      ARB_FORCE: state_d = last ? ARB_IDLE : pop ? ARB_PEND : ARB_FORCE;
      default:   state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
    end
  end
endmodule
